mmu_yram_p2s: RTL
=================

Name: mmu_yram_p2s

Overview:
- Result-side counterpart of the convolution image store: a parallel-in, serial-out buffer.
- Accepts one KSIZE-lane wide word per handshake and emits it as ITERA = KSIZE/CORE_N consecutive CORE_N-lane beats.
- Each beat carries a write address compatible with the per-bank addressing of the serial-in / parallel-out image RAM.
- Sits between the convolution array output and the CORE_N-wide writeback/DMA path; a 2-entry wide buffer decouples the array from downstream backpressure.

Parameters:
- INTWIDTH, `INTWIDTH (16): bits per lane.
- CORE_N, `CORE_N (4): lanes per output beat.
- KSIZE, `KSIZE (16): lanes per input word; KSIZE = ITERA*CORE_N.
- VAW, `VAW (8): address width.
- ITERA, KSIZE/CORE_N (4): beats per word. Derived, not overridable. Must be a power of 2 and >= 2.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-high (asserted = 1).
- Y_din  in  INTWIDTH*KSIZE  wide input word; lane i = bits [INTWIDTH*(i+1)-1 : INTWIDTH*i].
- Y_din_addr  in  VAW  word address.
- Y_din_valid  in  1  input word valid.
- Y_din_ready  out  1  buffer can accept a word.
- Y_dout  out  INTWIDTH*CORE_N  current beat.
- Y_dout_addr  out  VAW  beat address.
- Y_dout_valid  out  1  beat valid.
- Y_dout_ready  in  1  downstream accepts beat.
- Y_dout_last  out  1  current beat is the final beat of its word.
- busy  out  1  at least one word is buffered.
- word_done  out  1  one-cycle pulse after the last beat of a word is accepted.

Behaviour:
- Reset state: count=0, wr_ptr=0, rd_ptr=0, beat=0, FSM=IDLE.
- Reset output values: Y_din_ready=1, Y_dout_valid=0, Y_dout_last=0, busy=0, word_done=0, Y_dout=0, Y_dout_addr=0. Reset acts immediately (async), including mid-word; buffered data is discarded.
- Storage: 2-entry wide FIFO, each entry {data, addr}. count in 0..2.
  - Push when Y_din_valid & Y_din_ready at a clock edge.
  - Y_din_ready = (count != 2), from registered state only. No combinational path from Y_din_valid or Y_dout_ready to Y_din_ready.
  - A slot freed by a pop becomes visible the cycle after the pop; no same-cycle pass-through when full.
- FSM:
  - IDLE: count == 0. Moves to STREAM on the push edge.
  - STREAM: beat counter 0..ITERA-1 indexes the head entry.
    - On Y_dout_valid & Y_dout_ready: if beat < ITERA-1, beat++.
    - Otherwise beat=0, pop the head, and pulse word_done in the next cycle. Then stay in STREAM if count after pop/push > 0, else go to IDLE.
- Output functions (all derived from registers):
  - Y_dout_valid = (count != 0).
  - Y_dout = head lanes [beat*CORE_N +: CORE_N]; lane 0 goes out first, in the lowest bits.
  - Y_dout_addr = (head_addr*ITERA + beat) mod 2^VAW.
  - Y_dout_last = Y_dout_valid & (beat == ITERA-1).
  - busy = (count != 0).
- Latency: a word accepted at edge T produces beat 0 valid in the cycle following T (1 cycle).
- Throughput: with Y_dout_ready held high, successive words stream with no bubble, one beat per cycle.
- Backpressure: while Y_dout_ready=0, Y_dout, Y_dout_addr and Y_dout_last hold stable.
- Simultaneous push and last-beat pop with count=1: count stays 1, the new word becomes head, and beat 0 of it follows immediately.
- A push is impossible at count=2 (ready low), so there is no overflow. Y_din_valid is ignored while ready=0.
- Address wrap: the multiply is truncated to VAW bits; no error is flagged.

Decomposition:
- INTWIDTH, CORE_N, KSIZE and VAW come from the shared config.v defines. ITERA and the beat-counter width are localparams.
- The natural sub-module is mmu_wfifo2: a 2-entry, parameter-width FIFO with count, full and empty outputs. The top level holds the beat counter, FSM and lane mux.

Test Plan:
All scenarios use INTWIDTH=16, CORE_N=4, KSIZE=16, VAW=8.
1. Reset: assert rst_n=1 mid-clock -> outputs go to reset values with no clock edge; after release, Y_din_ready=1 and busy=0.
2. Single word: push addr=5, lanes 0..15 = 0x0000..0x000F, Y_dout_ready=1.
   -> Beats in the 4 cycles after the push edge, addr 20, 21, 22, 23.
   -> Beat 0 = {0x0003,0x0002,0x0001,0x0000}; Y_dout_last only on addr 23.
   -> word_done pulses once, then busy=0.
3. Back-to-back: Y_din_valid held for 3 words (addr 1, 2, 3).
   -> Y_din_ready drops once count=2.
   -> 12 contiguous beats with addr 4..15 and no bubble; every word accepted exactly once.
4. Backpressure: drop Y_dout_ready for 3 cycles at beat 1 of addr 5 -> Y_dout and Y_dout_addr=21 stable for those cycles, then the sequence resumes with 22, 23.
5. Wrap: push addr=0x41 -> beat addresses 0x04, 0x05, 0x06, 0x07.
6. Reset mid-stream at beat 2 with count=2 -> Y_dout_valid=0 immediately; after release, a new push of addr 9 starts at beat 0 with addr 36.

Source files
------------

// File: rtl/mmu_yram_p2s_pkg.sv
// ----------------------------------------------------------------------------
// mmu_yram_p2s_pkg
// Shared definitions for the result-side parallel-in / serial-out buffer.
//   - Default geometry (bits per lane, lanes per beat, lanes per word,
//     address width) used as parameter defaults by the top level.
//   - State encoding of the beat-streaming FSM.
// ----------------------------------------------------------------------------
package mmu_yram_p2s_pkg;

    localparam int P2S_INTWIDTH = 16;
    localparam int P2S_CORE_N   = 4;
    localparam int P2S_KSIZE    = 16;
    localparam int P2S_VAW      = 8;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } p2s_state_t;

endpackage

// File: rtl/mmu_yram_p2s_wfifo2.sv
// ----------------------------------------------------------------------------
// mmu_wfifo2
// Two-entry FIFO of arbitrary width; the head entry is always visible.
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-high reset (pointers and count only)
//   i_push   in   write i_din at the tail (ignored when full)
//   i_pop    in   drop the head entry (ignored when empty)
//   i_din    in   W-bit entry to write
//   o_head   out  current head entry
//   o_count  out  number of stored entries, 0..2
//   o_full   out  count == 2
//   o_empty  out  count == 0
// ----------------------------------------------------------------------------
module mmu_wfifo2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_din,
    output logic [W-1:0] o_head,
    output logic [1:0]   o_count,
    output logic         o_full,
    output logic         o_empty
);

    logic [W-1:0] r_mem0;
    logic [W-1:0] r_mem1;
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_count;
    logic         w_push;
    logic         w_pop;

    assign o_full  = (r_count == 2'd2);
    assign o_empty = (r_count == 2'd0);
    assign o_count = r_count;
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_head  = r_rd_ptr ? r_mem1 : r_mem0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage carries no reset: contents are only observed while count != 0.
    always_ff @(posedge clk) begin
        if (w_push) begin
            if (r_wr_ptr) r_mem1 <= i_din;
            else          r_mem0 <= i_din;
        end
    end

endmodule

// File: rtl/mmu_yram_p2s.sv
// ----------------------------------------------------------------------------
// mmu_yram_p2s
// Parallel-in / serial-out result buffer. Each accepted KSIZE-lane word is
// replayed as ITERA = KSIZE/CORE_N beats of CORE_N lanes, lane 0 first, each
// beat tagged with the per-bank write address head_addr*ITERA + beat.
// Ports:
//   clk           in   clock, rising edge
//   rst_n         in   asynchronous reset, active-high despite the name
//   Y_din         in   INTWIDTH*KSIZE wide input word
//   Y_din_addr    in   word address
//   Y_din_valid   in   input word valid
//   Y_din_ready   out  buffer has a free slot (registered state only)
//   Y_dout        out  current CORE_N-lane beat
//   Y_dout_addr   out  beat address (truncated to VAW bits)
//   Y_dout_valid  out  beat valid
//   Y_dout_ready  in   downstream accepts beat
//   Y_dout_last   out  current beat is the final one of its word
//   busy          out  at least one word is buffered
//   word_done     out  one-cycle pulse after a word's last beat is accepted
// ----------------------------------------------------------------------------
module mmu_yram_p2s
    import mmu_yram_p2s_pkg::*;
#(
    parameter int INTWIDTH = P2S_INTWIDTH,
    parameter int CORE_N   = P2S_CORE_N,
    parameter int KSIZE    = P2S_KSIZE,
    parameter int VAW      = P2S_VAW
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [INTWIDTH*KSIZE-1:0]    Y_din,
    input  logic [VAW-1:0]               Y_din_addr,
    input  logic                         Y_din_valid,
    output logic                         Y_din_ready,
    output logic [INTWIDTH*CORE_N-1:0]   Y_dout,
    output logic [VAW-1:0]               Y_dout_addr,
    output logic                         Y_dout_valid,
    input  logic                         Y_dout_ready,
    output logic                         Y_dout_last,
    output logic                         busy,
    output logic                         word_done
);

    localparam int ITERA  = KSIZE / CORE_N;
    localparam int BW     = $clog2(ITERA);
    localparam int BEAT_W = INTWIDTH * CORE_N;
    localparam int WORD_W = INTWIDTH * KSIZE;
    localparam int ENT_W  = WORD_W + VAW;
    localparam logic [BW-1:0] LAST_BEAT = BW'(ITERA - 1);

    p2s_state_t        r_state;
    logic [BW-1:0]     r_beat;
    logic              r_word_done;

    logic [ENT_W-1:0]  w_head;
    logic [WORD_W-1:0] w_head_data;
    logic [VAW-1:0]    w_head_addr;
    logic [1:0]        w_count;
    logic [1:0]        w_count_nxt;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_fire;
    logic              w_last_beat;
    logic              w_pop;
    logic [BEAT_W-1:0] w_beats [ITERA];
    logic [VAW-1:0]    w_beat_addr;

    mmu_wfifo2 #(
        .W(ENT_W)
    ) u_wfifo (
        .clk     (clk),
        .rst     (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   ({Y_din, Y_din_addr}),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_head_data = w_head[ENT_W-1:VAW];
    assign w_head_addr = w_head[VAW-1:0];

    // Ready comes straight from the stored count, so a slot freed by a pop
    // only shows up on the following cycle.
    assign Y_din_ready = ~w_full;
    assign w_push      = Y_din_valid & Y_din_ready;
    assign w_fire      = Y_dout_valid & Y_dout_ready;
    assign w_last_beat = (r_beat == LAST_BEAT);
    assign w_pop       = w_fire & w_last_beat;

    always_comb begin
        w_count_nxt = w_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = w_count + 2'd1;
            2'b01:   w_count_nxt = w_count - 2'd1;
            default: w_count_nxt = w_count;
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state     <= ST_IDLE;
            r_beat      <= '0;
            r_word_done <= 1'b0;
        end else begin
            r_word_done <= w_pop;
            case (r_state)
                ST_IDLE: begin
                    r_beat <= '0;
                    if (w_push) r_state <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (w_fire) begin
                        if (w_last_beat) begin
                            r_beat <= '0;
                            if (w_count_nxt == 2'd0) r_state <= ST_IDLE;
                        end else begin
                            r_beat <= r_beat + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_beat  <= '0;
                end
            endcase
        end
    end

    // Split the head word into beats; beat b holds lanes b*CORE_N .. b*CORE_N+CORE_N-1.
    for (genvar g = 0; g < ITERA; g++) begin : g_beats
        assign w_beats[g] = w_head_data[g*BEAT_W +: BEAT_W];
    end

    // ITERA is a power of two, so head_addr*ITERA + beat is a shift plus OR;
    // the shift drops the top bits, giving the mod 2^VAW wrap.
    assign w_beat_addr = (w_head_addr << BW) | VAW'(r_beat);

    assign Y_dout_valid = ~w_empty;
    assign busy         = ~w_empty;
    assign Y_dout_last  = Y_dout_valid & w_last_beat;
    assign Y_dout       = Y_dout_valid ? w_beats[r_beat] : '0;
    assign Y_dout_addr  = Y_dout_valid ? w_beat_addr : '0;
    assign word_done    = r_word_done;

endmodule
